account_auth: RTL and testbench
===============================

# account_auth

Card/PIN authentication and account storage stage sitting directly upstream of the ATM transaction FSM. It holds a small table of accounts, each with a PIN, a balance and a failure count. It accepts a card ID and decimal PIN digits, then produces `psw_en`, `wrong_psw` and `current_balance` for the FSM. When the FSM ejects the card, it writes the final session balance back into the table.

## Interface
- `ACCOUNTS`, default 4: number of table entries; must equal 2**`ID_WIDTH`.
- `ID_WIDTH`, default 2: card ID width.
- `balance_width`, default 20: balance width; matches the FSM parameter.
- `PIN_DIGITS`, default 4: decimal digits per PIN; PIN stored as `4*PIN_DIGITS` bits of BCD.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `prog_en` in 1: write `prog_pin` and `prog_balance` into entry `prog_id`.
- `prog_id` in `ID_WIDTH`: entry index for a table write.
- `prog_pin` in `4*PIN_DIGITS`: BCD PIN for a table write.
- `prog_balance` in `balance_width`: balance for a table write.
- `card_in` in 1: card insertion strobe.
- `card_id` in `ID_WIDTH`: account index presented with `card_in`.
- `digit_valid` in 1: `digit` is valid this cycle.
- `digit` in 4: BCD digit.
- `timeout` in 1: session timer expiry.
- `card_out` in 1: card eject from the FSM; ends the session.
- `wb_balance` in `balance_width`: final balance, sampled together with `card_out`.
- `psw_en` out 1: one-cycle pulse, card accepted.
- `current_balance` out `balance_width`: balance of the session account.
- `wrong_psw` out 1: one-cycle pulse, PIN mismatch.
- `pin_ok` out 1: one-cycle pulse, PIN match.
- `card_reject` out 1: one-cycle pulse, card refused because the account is locked.
- `locked` out 1: session account is locked; level.
- `busy` out 1: state is not IDLE.

## Operation
- States: IDLE, LOAD, ENTRY, CHECK, SESSION.
- **IDLE**
  - `prog_en` writes the table entry and clears that entry's fail count and lock bit.
  - `prog_en` takes priority over a simultaneous `card_in`; the card is dropped.
  - `card_in` latches `card_id` and goes to LOAD.
- **LOAD**
  - Locked account: `card_reject` pulse, back to IDLE.
  - Otherwise: `psw_en` pulse, `current_balance` loaded, digit shift register and digit count cleared, go to ENTRY.
- **ENTRY**
  - Each `digit_valid` with `digit` ≤ 9 shifts into the register: first digit ends in the most significant nibble, count increments.
  - Digits 10–15 are ignored; no shift, no count change.
  - When the count reaches `PIN_DIGITS`, go to CHECK.
- **CHECK**: compare the register against the stored PIN.
  - Match: `pin_ok` pulse, fail count cleared, go to SESSION.
  - Mismatch: `wrong_psw` pulse, fail count incremented, register and count cleared, back to ENTRY (lockout exception under Configuration).
- **SESSION**: `card_out` writes `wb_balance` into the session entry and `current_balance`, then returns to IDLE.
- `timeout` in LOAD, ENTRY or CHECK aborts to IDLE. No table write occurs and the fail count is kept.
- `card_in`, `prog_en` and `digit_valid` outside their accepting states are ignored.
- `card_out` outside SESSION is ignored.
- `current_balance` holds its value between sessions.

## Timing
- Reset: state IDLE; every table entry gets PIN 0 and balance 0, fail count 0, unlocked.
- Reset values of outputs: `current_balance`, `psw_en`, `wrong_psw`, `pin_ok`, `card_reject`, `locked` and `busy` all 0.
- Reset asserted mid-session discards the session; no write-back.
- All outputs are registered.
- Card path: `card_in` sampled at edge E → `psw_en` or `card_reject` high from E+1 to E+2. `current_balance` is valid from E+1.
- PIN path: last digit sampled at edge E → `pin_ok` or `wrong_psw` high from E+1 to E+2 (CHECK lasts one cycle).
- The earliest next digit is accepted at edge E+2.
- `card_out` sampled at edge E → table entry and `current_balance` updated at E; `busy` low from E.
- `timeout` takes precedence over a same-cycle last digit or `card_out`.

## Configuration
- `AUTH_LOCKOUT_EN` defined:
  - A mismatch that brings the fail count to 3 sets the entry's lock bit.
  - `locked` goes high and the state returns to IDLE after the `wrong_psw` pulse.
  - A later `card_in` for that entry gives `card_reject`.
  - `locked` is high while the selected account's lock bit is set.
- `AUTH_LOCKOUT_EN` undefined:
  - No lock bits exist; unlimited retries.
  - `card_reject` and `locked` are tied to 0.

## Test plan
- Program id 1 with PIN 1234 and balance 500; `card_in` with id 1; digits 1,2,3,4 → `psw_en` pulse with `current_balance`=500, then `pin_ok` two edges after digit 4.
- Same account; digits 1,2,3,5 → `wrong_psw` pulse, state back to ENTRY; then 1,2,3,4 → `pin_ok`.
- In SESSION, assert `card_out` with `wb_balance`=320 → `busy` falls; a new session on id 1 shows `current_balance`=320.
- Digit 11 injected between 1 and 2 is ignored → PIN 1234 still gives `pin_ok`.
- `timeout` after two digits → IDLE, no `wrong_psw`, balance unchanged.
- With `AUTH_LOCKOUT_EN`: three wrong PINs → third `wrong_psw`, `locked`=1, IDLE.
  - Next `card_in` with id 1 → `card_reject`, no `psw_en`.
  - Reprogramming id 1 → accepted again.

Source files
------------

// File: rtl/account_auth.sv
// account_auth: card/PIN authentication front end with a small account table.
// Holds a PIN, a balance and a failure count for each account, runs the card
// and PIN handshake, and stores the final session balance when the card is
// ejected.
// Optional feature: define AUTH_LOCKOUT_EN to lock an account after three
// consecutive PIN mismatches. Without it, retries are unlimited and
// card_reject/locked stay 0.
module account_auth #(
  parameter int unsigned ACCOUNTS      = 4,
  parameter int unsigned ID_WIDTH      = 2,
  parameter int unsigned balance_width = 20,
  parameter int unsigned PIN_DIGITS    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     prog_en,
  input  logic [ID_WIDTH-1:0]      prog_id,
  input  logic [4*PIN_DIGITS-1:0]  prog_pin,
  input  logic [balance_width-1:0] prog_balance,
  input  logic                     card_in,
  input  logic [ID_WIDTH-1:0]      card_id,
  input  logic                     digit_valid,
  input  logic [3:0]               digit,
  input  logic                     timeout,
  input  logic                     card_out,
  input  logic [balance_width-1:0] wb_balance,
  output logic                     psw_en,
  output logic [balance_width-1:0] current_balance,
  output logic                     wrong_psw,
  output logic                     pin_ok,
  output logic                     card_reject,
  output logic                     locked,
  output logic                     busy
);

  localparam int unsigned PIN_W  = 4 * PIN_DIGITS;
  localparam int unsigned CNT_W  = $clog2(PIN_DIGITS + 1);
  localparam int unsigned FAIL_W = 2;
  localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(3);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ENTRY,
    CHECK,
    SESSION
  } state_t;

  state_t                   state;
  logic [PIN_W-1:0]         pin_tab  [ACCOUNTS];
  logic [balance_width-1:0] bal_tab  [ACCOUNTS];
  logic [FAIL_W-1:0]        fail_tab [ACCOUNTS];
  logic [ID_WIDTH-1:0]      sel_id;
  logic [PIN_W-1:0]         pin_sr;
  logic [CNT_W-1:0]         dig_cnt;
  logic [FAIL_W-1:0]        fail_inc;

`ifdef AUTH_LOCKOUT_EN
  logic [ACCOUNTS-1:0]      lock_tab;
`else
  assign card_reject = 1'b0;
  assign locked      = 1'b0;
`endif

  // Saturating next fail count of the session account.
  always_comb begin
    fail_inc = fail_tab[sel_id];
    if (fail_tab[sel_id] != FAIL_MAX) begin
      fail_inc = fail_tab[sel_id] + FAIL_W'(1);
    end
  end

  // Session FSM, account table and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      sel_id          <= '0;
      pin_sr          <= '0;
      dig_cnt         <= '0;
      current_balance <= '0;
      psw_en          <= 1'b0;
      wrong_psw       <= 1'b0;
      pin_ok          <= 1'b0;
      busy            <= 1'b0;
      for (int i = 0; i < int'(ACCOUNTS); i++) begin
        pin_tab[i]  <= '0;
        bal_tab[i]  <= '0;
        fail_tab[i] <= '0;
      end
`ifdef AUTH_LOCKOUT_EN
      lock_tab    <= '0;
      card_reject <= 1'b0;
      locked      <= 1'b0;
`endif
    end else begin
      psw_en    <= 1'b0;
      wrong_psw <= 1'b0;
      pin_ok    <= 1'b0;
`ifdef AUTH_LOCKOUT_EN
      card_reject <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (prog_en) begin
            pin_tab[prog_id]  <= prog_pin;
            bal_tab[prog_id]  <= prog_balance;
            fail_tab[prog_id] <= '0;
`ifdef AUTH_LOCKOUT_EN
            lock_tab[prog_id] <= 1'b0;
            if (prog_id == sel_id) begin
              locked <= 1'b0;
            end
`endif
          end else if (card_in) begin
            sel_id <= card_id;
            state  <= LOAD;
            busy   <= 1'b1;
`ifdef AUTH_LOCKOUT_EN
            locked <= lock_tab[card_id];
`endif
          end
        end

        LOAD: begin
          if (timeout) begin
            state <= IDLE;
            busy  <= 1'b0;
`ifdef AUTH_LOCKOUT_EN
          end else if (lock_tab[sel_id]) begin
            card_reject <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
`endif
          end else begin
            psw_en          <= 1'b1;
            current_balance <= bal_tab[sel_id];
            pin_sr          <= '0;
            dig_cnt         <= '0;
            state           <= ENTRY;
          end
        end

        ENTRY: begin
          if (timeout) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (digit_valid && (digit <= 4'd9)) begin
            // First digit ends up in the most significant nibble.
            pin_sr  <= (pin_sr << 4) | PIN_W'(digit);
            dig_cnt <= dig_cnt + CNT_W'(1);
            if (dig_cnt == CNT_W'(PIN_DIGITS - 1)) begin
              state <= CHECK;
            end
          end
        end

        CHECK: begin
          if (timeout) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (pin_sr == pin_tab[sel_id]) begin
            pin_ok           <= 1'b1;
            fail_tab[sel_id] <= '0;
            state            <= SESSION;
          end else begin
            wrong_psw        <= 1'b1;
            fail_tab[sel_id] <= fail_inc;
            pin_sr           <= '0;
            dig_cnt          <= '0;
            state            <= ENTRY;
`ifdef AUTH_LOCKOUT_EN
            if (fail_inc == FAIL_MAX) begin
              lock_tab[sel_id] <= 1'b1;
              locked           <= 1'b1;
              state            <= IDLE;
              busy             <= 1'b0;
            end
`endif
          end
        end

        SESSION: begin
          if (card_out) begin
            bal_tab[sel_id] <= wb_balance;
            current_balance <= wb_balance;
            state           <= IDLE;
            busy            <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_account_auth.sv
// Testbench for account_auth: directed scenarios followed by randomized
// sessions, checked against a transaction-level account model.
module tb_account_auth;

  localparam int unsigned IDW = 2;
  localparam int unsigned ACC = 4;
  localparam int unsigned BW  = 20;
  localparam int unsigned PD  = 4;

`ifdef AUTH_LOCKOUT_EN
  localparam bit LOCKOUT = 1'b1;
`else
  localparam bit LOCKOUT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          prog_en;
  logic [IDW-1:0] prog_id;
  logic [4*PD-1:0] prog_pin;
  logic [BW-1:0] prog_balance;
  logic          card_in;
  logic [IDW-1:0] card_id;
  logic          digit_valid;
  logic [3:0]    digit;
  logic          timeout;
  logic          card_out;
  logic [BW-1:0] wb_balance;
  logic          psw_en;
  logic [BW-1:0] current_balance;
  logic          wrong_psw;
  logic          pin_ok;
  logic          card_reject;
  logic          locked;
  logic          busy;

  account_auth #(
    .ACCOUNTS(ACC), .ID_WIDTH(IDW), .balance_width(BW), .PIN_DIGITS(PD)
  ) dut (
    .clk(clk), .rst(rst), .prog_en(prog_en), .prog_id(prog_id),
    .prog_pin(prog_pin), .prog_balance(prog_balance), .card_in(card_in),
    .card_id(card_id), .digit_valid(digit_valid), .digit(digit),
    .timeout(timeout), .card_out(card_out), .wb_balance(wb_balance),
    .psw_en(psw_en), .current_balance(current_balance),
    .wrong_psw(wrong_psw), .pin_ok(pin_ok), .card_reject(card_reject),
    .locked(locked), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Account model: table contents plus where the session stands.
  logic [15:0]   m_pin  [ACC];
  logic [BW-1:0] m_bal  [ACC];
  int            m_fail [ACC];
  bit            m_lock [ACC];
  logic [BW-1:0] m_cur;
  int            m_sel;
  bit            m_locked_out;
  bit            in_entry;
  bit            in_session;
  logic [15:0]   m_acc;
  int            m_n;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    prog_en = 1'b0; prog_id = '0; prog_pin = '0; prog_balance = '0;
    card_in = 1'b0; card_id = '0; digit_valid = 1'b0; digit = '0;
    timeout = 1'b0; card_out = 1'b0; wb_balance = '0;
  endtask

  function automatic logic [15:0] rand_pin();
    logic [15:0] p = '0;
    for (int i = 0; i < int'(PD); i++) p = (p << 4) | 16'($urandom_range(9));
    return p;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < int'(ACC); i++) begin
      m_pin[i] = '0; m_bal[i] = '0; m_fail[i] = 0; m_lock[i] = 1'b0;
    end
    m_cur = '0; m_sel = 0; m_locked_out = 1'b0;
    in_entry = 1'b0; in_session = 1'b0; m_acc = '0; m_n = 0;
    check_val("rst_psw_en", psw_en, 0);
    check_val("rst_wrong_psw", wrong_psw, 0);
    check_val("rst_pin_ok", pin_ok, 0);
    check_val("rst_card_reject", card_reject, 0);
    check_val("rst_locked", locked, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_balance", current_balance, 0);
  endtask

  task automatic prog_acct(input int id, input logic [15:0] pin, input logic [BW-1:0] bal,
                           input bit with_card);
    prog_en = 1'b1; prog_id = IDW'(id); prog_pin = pin; prog_balance = bal;
    card_in = with_card; card_id = IDW'($urandom_range(ACC - 1));
    tick();
    prog_en = 1'b0; card_in = 1'b0;
    m_pin[id] = pin; m_bal[id] = bal; m_fail[id] = 0; m_lock[id] = 1'b0;
    m_locked_out = m_lock[m_sel];
    check_val("prog_busy", busy, 0);
    check_val("prog_locked", locked, 32'(m_locked_out));
  endtask

  task automatic insert_card(input int id);
    card_in = 1'b1; card_id = IDW'(id);
    tick();
    card_in = 1'b0;
    m_sel = id;
    m_locked_out = m_lock[id];
    check_val("load_busy", busy, 1);
    check_val("load_psw_early", psw_en, 0);
    tick();
    if (m_lock[id]) begin
      check_val("reject_pulse", card_reject, 1);
      check_val("reject_no_psw", psw_en, 0);
      check_val("reject_busy", busy, 0);
    end else begin
      m_cur = m_bal[id];
      in_entry = 1'b1; m_acc = '0; m_n = 0;
      check_val("psw_en_pulse", psw_en, 1);
      check_val("accept_no_reject", card_reject, 0);
    end
    check_val("load_balance", current_balance, 32'(m_cur));
    check_val("load_locked", locked, 32'(m_locked_out));
  endtask

  task automatic send_digit(input logic [3:0] d, input bit tout);
    digit_valid = 1'b1; digit = d; timeout = tout;
    tick();
    digit_valid = 1'b0; timeout = 1'b0;
    if (tout) begin
      in_entry = 1'b0; m_acc = '0; m_n = 0;
      check_val("tout_busy", busy, 0);
      tick();
      check_val("tout_no_wrong", wrong_psw, 0);
      check_val("tout_no_ok", pin_ok, 0);
      check_val("tout_balance", current_balance, 32'(m_cur));
      return;
    end
    if (d <= 4'd9) begin
      m_acc = (m_acc << 4) | 16'(d);
      m_n++;
    end
    if (m_n < int'(PD)) begin
      check_val("entry_no_ok", pin_ok, 0);
      check_val("entry_no_wrong", wrong_psw, 0);
      check_val("entry_busy", busy, 1);
      return;
    end
    tick();
    if (m_acc == m_pin[m_sel]) begin
      m_fail[m_sel] = 0;
      in_entry = 1'b0; in_session = 1'b1;
      check_val("pin_ok_pulse", pin_ok, 1);
      check_val("pin_ok_no_wrong", wrong_psw, 0);
      check_val("session_busy", busy, 1);
    end else begin
      m_fail[m_sel]++;
      if (LOCKOUT && m_fail[m_sel] >= 3) begin
        m_lock[m_sel] = 1'b1;
        m_locked_out = 1'b1;
        in_entry = 1'b0;
      end
      m_acc = '0; m_n = 0;
      check_val("wrong_psw_pulse", wrong_psw, 1);
      check_val("wrong_no_ok", pin_ok, 0);
      check_val("mismatch_busy", busy, 32'(in_entry));
    end
    check_val("check_locked", locked, 32'(m_locked_out));
  endtask

  task automatic send_pin(input logic [15:0] p);
    for (int i = int'(PD) - 1; i >= 0; i--) begin
      logic [15:0] sh;
      sh = p >> (4 * i);
      send_digit(sh[3:0], 1'b0);
    end
  endtask

  task automatic eject(input logic [BW-1:0] wb);
    card_out = 1'b1; wb_balance = wb;
    tick();
    card_out = 1'b0;
    if (in_session) begin
      m_bal[m_sel] = wb;
      m_cur = wb;
      in_session = 1'b0;
    end
    check_val("eject_busy", busy, 32'(in_entry || in_session));
    check_val("eject_balance", current_balance, 32'(m_cur));
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    do_reset();

    // Basic accept and write-back.
    prog_acct(1, 16'h1234, BW'(500), 1'b0);
    insert_card(1);
    check_val("plan_bal_500", current_balance, 500);
    send_pin(16'h1234);
    eject(BW'(320));
    insert_card(1);
    check_val("plan_bal_320", current_balance, 320);

    // Wrong PIN, then right PIN.
    send_pin(16'h1235);
    send_pin(16'h1234);
    eject(BW'(777));

    // Invalid digit ignored, card_out outside SESSION ignored.
    insert_card(1);
    send_digit(4'd1, 1'b0);
    send_digit(4'd11, 1'b0);
    eject(BW'(5));
    send_digit(4'd2, 1'b0);
    send_digit(4'd15, 1'b0);
    send_digit(4'd3, 1'b0);
    send_digit(4'd4, 1'b0);
    eject(BW'(600));

    // Timeout after two digits; timeout beating a last digit.
    insert_card(1);
    send_digit(4'd1, 1'b0);
    send_digit(4'd2, 1'b0);
    send_digit(4'd3, 1'b1);
    insert_card(1);
    send_digit(4'd1, 1'b0);
    send_digit(4'd2, 1'b0);
    send_digit(4'd3, 1'b0);
    send_digit(4'd4, 1'b1);

    // Programming beats a simultaneous card.
    prog_acct(2, 16'h9876, BW'(12345), 1'b1);
    insert_card(2);
    send_pin(16'h9876);
    eject(BW'(1000));

`ifdef AUTH_LOCKOUT_EN
    // Three mismatches lock the account; reprogramming unlocks it.
    insert_card(1);
    send_pin(16'h0000);
    send_pin(16'h1111);
    send_pin(16'h2222);
    check_val("lock_level", locked, 1);
    check_val("lock_idle", busy, 0);
    insert_card(1);
    check_val("lock_reject_level", locked, 1);
    insert_card(2);
    check_val("other_unlocked", locked, 0);
    send_digit(4'd0, 1'b1);
    prog_acct(1, 16'h4321, BW'(42), 1'b0);
    insert_card(1);
    check_val("unlock_balance", current_balance, 42);
    send_pin(16'h4321);
    eject(BW'(43));
`endif

    // Randomized sessions.
    for (int s = 0; s < 150; s++) begin
      int id;
      if ($urandom_range(3) == 0)
        prog_acct(int'($urandom_range(ACC - 1)), rand_pin(), BW'($urandom), bit'($urandom_range(1)));
      id = int'($urandom_range(ACC - 1));
      insert_card(id);
      for (int k = 0; k < 30 && in_entry; k++) begin
        int r;
        logic [15:0] sh;
        r = int'($urandom_range(99));
        sh = m_pin[m_sel] >> (4 * (int'(PD) - 1 - m_n));
        if (r < 4)       send_digit(4'($urandom_range(9)), 1'b1);
        else if (r < 10) send_digit(4'(10 + $urandom_range(5)), 1'b0);
        else if (r < 14) eject(BW'($urandom));
        else if (r < 20) tick();
        else if (r < 85) send_digit(sh[3:0], 1'b0);
        else             send_digit(4'($urandom_range(9)), 1'b0);
      end
      if (in_entry) send_digit(4'd0, 1'b1);
      if (in_session) begin
        if ($urandom_range(1) == 1) tick();
        eject(BW'($urandom));
      end
    end

    // Reset in the middle of a session discards it.
    prog_acct(3, 16'h5555, BW'(900), 1'b0);
    insert_card(3);
    send_pin(16'h5555);
    do_reset();
    insert_card(3);
    check_val("post_rst_balance", current_balance, 0);
    send_pin(16'h0000);
    eject(BW'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
